spi_req_arbiter: RTL
====================

SPI_REQ_ARBITER -- requirements
Module: spi_req_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one SPI master.
REQ-002 Parameter DATA_WIDTH, default 32, SPI word width.
REQ-003 Parameter NUM_SLAVES, default 4, number of slave-select lines.
REQ-004 Parameter TIMEOUT_CYCLES, default 65535, watchdog limit in clk cycles.
REQ-005 The block SHALL use one clock and a reset that is synchronous and active-high, exactly as already decided.
REQ-006 clk  in  1  system clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 req  in  NUM_REQ  per-requester transfer request, level.
REQ-009 req_slave  in  NUM_REQ*SLV_W  per-requester slave index; SLV_W = clog2(NUM_SLAVES), min 1.
REQ-010 req_data  in  NUM_REQ*DATA_WIDTH  per-requester TX word.
REQ-011 gnt  out  NUM_REQ  one-hot owner, held from grant to done.
REQ-012 done  out  NUM_REQ  one-cycle completion pulse to owner.
REQ-013 rsp_data  out  DATA_WIDTH  RX word of last completed transfer.
REQ-014 rsp_err  out  1  qualifies done; 1 = bad slave index or timeout.
REQ-015 spi_start  out  1  one-cycle start pulse to SPI master.
REQ-016 spi_tx_data  out  DATA_WIDTH  latched TX word.
REQ-017 spi_ss_sel  out  NUM_SLAVES  one-hot slave select, active-high.
REQ-018 spi_busy  in  1  SPI master busy.
REQ-019 spi_done  in  1  SPI master completion pulse (irq).
REQ-020 spi_rx_data  in  DATA_WIDTH  SPI master received word.

Function
REQ-021 FSM states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RESP; any undefined encoding SHALL go to IDLE.
REQ-022 IDLE: when any req bit is set, grant the first set bit at or after rr_ptr (round-robin, wrap NUM_REQ-1 -> 0); gnt, spi_tx_data, spi_ss_sel registered on that edge; go to LAUNCH.
REQ-023 rr_ptr SHALL become winner+1 (mod NUM_REQ) at grant.
REQ-024 Slave index >= NUM_SLAVES at grant: skip SPI, rsp_err=1, rsp_data=0, go directly to RESP.
REQ-025 LAUNCH: spi_start=1 for exactly one cycle; go to WAIT_BUSY.
REQ-026 WAIT_BUSY: on spi_busy=1 go to WAIT_DONE; spi_done=1 here SHALL be accepted as completion (fast master).
REQ-027 WAIT_DONE: on spi_done=1 capture spi_rx_data into rsp_data, rsp_err=0, go to RESP.
REQ-028 RESP: done[owner]=1 one cycle, gnt cleared, return to IDLE; next grant no earlier than the following cycle (grant-to-grant minimum 4 cycles).
REQ-029 Requester deasserting req after grant SHALL NOT abort the transfer; done still pulses.
REQ-030 rsp_data and rsp_err SHALL hold until the next RESP.
REQ-031 spi_ss_sel SHALL be all-zero outside LAUNCH/WAIT_BUSY/WAIT_DONE.
REQ-032 spi_done outside WAIT_BUSY/WAIT_DONE SHALL be ignored.

Reset
REQ-033 rst=1 SHALL force IDLE, rr_ptr=0, gnt=0, done=0, rsp_data=0, rsp_err=0, spi_start=0, spi_tx_data=0, spi_ss_sel=0, watchdog=0.
REQ-034 Reset mid-transfer SHALL abandon it with no done pulse.

Configuration
REQ-035 Macro SPI_ARB_TIMEOUT_EN defined: watchdog counts cycles in WAIT_BUSY/WAIT_DONE; reaching TIMEOUT_CYCLES -> rsp_err=1, rsp_data=0, RESP.
REQ-036 Macro undefined: no counter logic; block waits indefinitely for spi_done.

Structure
REQ-037 Shared package spi_pkg SHALL hold the FSM state enum and the SLV_W clog2 helper.
REQ-038 Sub-module spi_rr_arbiter (combinational round-robin pick: req + rr_ptr -> one-hot winner) SHALL be instantiated once.

Verification
REQ-039 Single req[1], slave 2, data 0xA5A5A5A5, model returns 0x12345678 -> spi_ss_sel=4'b0100, spi_tx_data=0xA5A5A5A5, done[1] pulse, rsp_data=0x12345678, rsp_err=0.
REQ-040 req=4'b1111 held for 8 transfers from reset -> grant order 0,1,2,3,0,1,2,3.
REQ-041 req[3] with slave index 5, NUM_SLAVES=4 -> no spi_start, done[3] with rsp_err=1 within 3 cycles.
REQ-042 SPI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=100, model never signals spi_done -> done pulse at 100 cycles, rsp_err=1.
REQ-043 rst asserted in WAIT_DONE -> next cycle all outputs zero, no done pulse; fresh req[2] granted first.
REQ-044 req[0] dropped one cycle after grant -> transfer completes, done[0] pulses.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg
//   Shared definitions for the SPI request arbiter:
//   - spi_arb_state_e : arbiter FSM state encoding
//   - spi_clog2()     : ceil(log2(n)) with a floor of 1, used for index widths
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RESP      = 3'd4
  } spi_arb_state_e;

  // Width needed to index n items; a single item still gets one bit so
  // that every index bus has a legal, non-zero width.
  function automatic int spi_clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// spi_rr_arbiter
//   Purely combinational round-robin pick. Returns the first asserted request
//   at or after rr_ptr, wrapping from NUM_REQ-1 back to 0.
// Ports:
//   req     in  NUM_REQ  request vector
//   rr_ptr  in  PTR_W    highest-priority requester index
//   win_oh  out NUM_REQ  one-hot winner (all-zero when no request)
module spi_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] win_oh
);

  int   idx;
  logic found;

  always_comb begin
    win_oh = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        win_oh[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// spi_req_arbiter
//   Shares one SPI master among NUM_REQ requesters. A round-robin winner is
//   granted in IDLE, its TX word and slave select are latched, the master is
//   started, and the owner gets a one-cycle done pulse with rsp_data/rsp_err.
//   A slave index >= NUM_SLAVES is answered with an error without touching SPI.
// Optional feature:
//   SPI_ARB_TIMEOUT_EN  when defined, a watchdog aborts a transfer that spends
//                       TIMEOUT_CYCLES cycles waiting on the master (error
//                       response). When undefined the block waits forever.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   req           per-requester level request
//   req_slave     per-requester slave index (SLV_W bits each)
//   req_data      per-requester TX word
//   gnt           one-hot owner, held from grant through the done cycle
//   done          one-cycle completion pulse to the owner
//   rsp_data      RX word of the last completed transfer (0 on error)
//   rsp_err       error flag qualifying done
//   spi_start     one-cycle start pulse to the SPI master
//   spi_tx_data   latched TX word
//   spi_ss_sel    one-hot active-high slave select, zero when idle
//   spi_busy      master busy
//   spi_done      master completion pulse
//   spi_rx_data   master received word
module spi_req_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_REQ-1:0]                       req,
  input  logic [NUM_REQ*spi_clog2(NUM_SLAVES)-1:0] req_slave,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]            req_data,
  output logic [NUM_REQ-1:0]                       gnt,
  output logic [NUM_REQ-1:0]                       done,
  output logic [DATA_WIDTH-1:0]                    rsp_data,
  output logic                                     rsp_err,
  output logic                                     spi_start,
  output logic [DATA_WIDTH-1:0]                    spi_tx_data,
  output logic [NUM_SLAVES-1:0]                    spi_ss_sel,
  input  logic                                     spi_busy,
  input  logic                                     spi_done,
  input  logic [DATA_WIDTH-1:0]                    spi_rx_data
);

  localparam int SLV_W = spi_clog2(NUM_SLAVES);
  localparam int PTR_W = spi_clog2(NUM_REQ);

  // A zero or negative watchdog limit would make the timeout meaningless.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("spi_req_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  spi_arb_state_e          state_q, state_d;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d;
  logic [NUM_REQ-1:0]      done_q, done_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    spi_start_q, spi_start_d;
  logic [DATA_WIDTH-1:0]   spi_tx_data_q, spi_tx_data_d;
  logic [NUM_SLAVES-1:0]   spi_ss_sel_q, spi_ss_sel_d;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int WDOG_W = spi_clog2(TIMEOUT_CYCLES + 1);
  logic [WDOG_W-1:0]       wdog_q, wdog_d;
`endif

  logic [NUM_REQ-1:0]      win_oh;
  logic [PTR_W-1:0]        win_idx;
  logic [SLV_W-1:0]        win_slave;
  logic                    win_slave_bad;
  logic [NUM_SLAVES-1:0]   win_ss_dec;
  logic [DATA_WIDTH-1:0]   win_data;

  spi_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req     (req),
    .rr_ptr  (rr_ptr_q),
    .win_oh  (win_oh)
  );

  // Binary index of the one-hot winner, used to slice the per-requester buses.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) begin
        win_idx = PTR_W'(i);
      end
    end
  end

  assign win_slave     = req_slave[win_idx*SLV_W +: SLV_W];
  assign win_data      = req_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
  // Index width may exceed NUM_SLAVES when it is not a power of two.
  assign win_slave_bad = (32'(win_slave) >= 32'(NUM_SLAVES));

  always_comb begin
    win_ss_dec = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      if (32'(win_slave) == 32'(s)) begin
        win_ss_dec[s] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    gnt_d         = gnt_q;
    done_d        = '0;
    rsp_data_d    = rsp_data_q;
    rsp_err_d     = rsp_err_q;
    spi_start_d   = 1'b0;
    spi_tx_data_d = spi_tx_data_q;
    spi_ss_sel_d  = spi_ss_sel_q;
`ifdef SPI_ARB_TIMEOUT_EN
    wdog_d        = wdog_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          gnt_d         = win_oh;
          rr_ptr_d      = PTR_W'((int'(win_idx) + 1) % NUM_REQ);
          spi_tx_data_d = win_data;
          if (win_slave_bad) begin
            // No SPI activity: answer the owner with an error right away.
            state_d      = ST_RESP;
            done_d       = win_oh;
            rsp_err_d    = 1'b1;
            rsp_data_d   = '0;
            spi_ss_sel_d = '0;
          end else begin
            state_d      = ST_LAUNCH;
            spi_ss_sel_d = win_ss_dec;
            spi_start_d  = 1'b1;
          end
        end
      end

      ST_LAUNCH: begin
        state_d = ST_WAIT_BUSY;
`ifdef SPI_ARB_TIMEOUT_EN
        wdog_d  = '0;
`endif
      end

      ST_WAIT_BUSY, ST_WAIT_DONE: begin
`ifdef SPI_ARB_TIMEOUT_EN
        wdog_d = wdog_q + 1'b1;
`endif
        // A fast master may finish before busy was ever observed, so
        // spi_done completes the transfer in either wait state.
        if (spi_done) begin
          state_d      = ST_RESP;
          done_d       = gnt_q;
          rsp_data_d   = spi_rx_data;
          rsp_err_d    = 1'b0;
          spi_ss_sel_d = '0;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
          state_d      = ST_RESP;
          done_d       = gnt_q;
          rsp_data_d   = '0;
          rsp_err_d    = 1'b1;
          spi_ss_sel_d = '0;
        end
`endif
        else if ((state_q == ST_WAIT_BUSY) && spi_busy) begin
          state_d = ST_WAIT_DONE;
        end
      end

      ST_RESP: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d      = ST_IDLE;
        gnt_d        = '0;
        spi_ss_sel_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      gnt_q         <= '0;
      done_q        <= '0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      spi_start_q   <= 1'b0;
      spi_tx_data_q <= '0;
      spi_ss_sel_q  <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      wdog_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      gnt_q         <= gnt_d;
      done_q        <= done_d;
      rsp_data_q    <= rsp_data_d;
      rsp_err_q     <= rsp_err_d;
      spi_start_q   <= spi_start_d;
      spi_tx_data_q <= spi_tx_data_d;
      spi_ss_sel_q  <= spi_ss_sel_d;
`ifdef SPI_ARB_TIMEOUT_EN
      wdog_q        <= wdog_d;
`endif
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign spi_start   = spi_start_q;
  assign spi_tx_data = spi_tx_data_q;
  assign spi_ss_sel  = spi_ss_sel_q;

endmodule
